// File: rtl/alu_ops_pkg.sv
// Shared ALU op codes, execute-unit state type and op-class helper.
// Imported by the ALU controller and by the execute unit.
package alu_ops_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_XOR   = 4'b0001;
    localparam logic [3:0] OP_OR    = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_BEQ   = 4'b0101;
    localparam logic [3:0] OP_BNE   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_BGE   = 4'b1000;
    localparam logic [3:0] OP_SRL   = 4'b1001;
    localparam logic [3:0] OP_SLL   = 4'b1010;
    localparam logic [3:0] OP_SRA   = 4'b1011;
    localparam logic [3:0] OP_LUI   = 4'b1100;
    localparam logic [3:0] OP_RSV13 = 4'b1101;
    localparam logic [3:0] OP_RSV14 = 4'b1110;
    localparam logic [3:0] OP_RSV15 = 4'b1111;

    typedef enum logic {IDLE, SHIFT} exec_state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SRL) || (op == OP_SLL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_serial.sv
// Serial shifter: one bit per step, used for shift amounts > 0.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   abort        discard any shift in progress
//   start        load value/shamt/op (shamt must be non-zero)
//   step         advance one bit this cycle
//   op           SRL / SLL / SRA op code
//   value, shamt operand and shift amount captured on start
//   done         this step produces the final value
//   shifted      accumulator shifted by one bit
module alu_shift_serial
    import alu_ops_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              abort,
    input  logic              start,
    input  logic              step,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] value,
    input  logic [4:0]        shamt,
    output logic              done,
    output logic [DATA_W-1:0] shifted
);

    logic [DATA_W-1:0] acc_q, acc_d;
    logic [4:0]        count_q, count_d;
    logic [3:0]        op_q, op_d;

    always_comb begin
        case (op_q)
            OP_SRL:  shifted = acc_q >> 1;
            OP_SLL:  shifted = acc_q << 1;
            default: shifted = {acc_q[DATA_W-1], acc_q[DATA_W-1:1]};
        endcase
    end

    // Count holds the number of steps still to go, so the last step is at 1.
    assign done = step && (count_q == 5'd1);

    always_comb begin
        acc_d   = acc_q;
        count_d = count_q;
        op_d    = op_q;
        if (abort) begin
            count_d = '0;
        end else if (start) begin
            acc_d   = value;
            count_d = shamt;
            op_d    = op;
        end else if (step && (count_q != 5'd0)) begin
            acc_d   = shifted;
            count_d = count_q - 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '0;
            count_q <= '0;
            op_q    <= OP_SRL;
        end else begin
            acc_q   <= acc_d;
            count_q <= count_d;
            op_q    <= op_d;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/compare/LUI ops, serial shifts.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   flush               abort in-flight op and drop same-cycle input
//   in_valid/in_ready   operation handshake (in_ready low while shifting)
//   operation, src_a/b  op code and operands
//   tag_in / tag_out    destination tag in / of completed op
//   out_valid           one-cycle pulse when result/tag_out update
//   result              registered result
//
// state | meaning
// IDLE  | accepting ops; single-cycle ops complete here
// SHIFT | serial shift in progress, inputs ignored
module alu_exec_unit
    import alu_ops_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        operation,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] result,
    output logic [TAG_W-1:0]  tag_out
);

    exec_state_t       state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [TAG_W-1:0]  pend_tag_q, pend_tag_d;
    logic              out_valid_q, out_valid_d;

    logic [DATA_W-1:0] alu_res;
    logic [4:0]        shamt;
    logic              shift_start, shift_step, shift_done;
    logic [DATA_W-1:0] shift_res;

    assign shamt = src_b[4:0];

    // Shifts by zero finish here as a plain pass-through of operand A.
    always_comb begin
        case (operation)
            OP_AND:  alu_res = src_a & src_b;
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_ADD:  alu_res = src_a + src_b;
            OP_SUB:  alu_res = src_a - src_b;
            OP_BEQ:  alu_res = DATA_W'(src_a == src_b);
            OP_BNE:  alu_res = DATA_W'(src_a != src_b);
            OP_SLT:  alu_res = DATA_W'($signed(src_a) <  $signed(src_b));
            OP_BGE:  alu_res = DATA_W'($signed(src_a) >= $signed(src_b));
            OP_SRL, OP_SLL, OP_SRA: alu_res = src_a;
            OP_LUI:  alu_res = src_b;
            default: alu_res = '0;
        endcase
    end

    alu_shift_serial #(.DATA_W(DATA_W)) u_shift (
        .clk     (clk),
        .reset   (reset),
        .abort   (flush),
        .start   (shift_start),
        .step    (shift_step),
        .op      (operation),
        .value   (src_a),
        .shamt   (shamt),
        .done    (shift_done),
        .shifted (shift_res)
    );

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        tag_d       = tag_q;
        pend_tag_d  = pend_tag_q;
        out_valid_d = 1'b0;
        shift_start = 1'b0;
        shift_step  = 1'b0;
        in_ready    = (state_q == IDLE);
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (is_shift(operation) && (shamt != 5'd0)) begin
                            shift_start = 1'b1;
                            pend_tag_d  = tag_in;
                            state_d     = SHIFT;
                        end else begin
                            result_d    = alu_res;
                            tag_d       = tag_in;
                            out_valid_d = 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    shift_step = 1'b1;
                    if (shift_done) begin
                        result_d    = shift_res;
                        tag_d       = pend_tag_q;
                        out_valid_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            result_q    <= '0;
            tag_q       <= '0;
            pend_tag_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            tag_q       <= tag_d;
            pend_tag_q  <= pend_tag_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign tag_out   = tag_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid;
    logic [3:0]  operation;
    logic [31:0] src_a, src_b, result;
    logic [4:0]  tag_in, tag_out;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.DATA_W(32), .TAG_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operation (operation),
        .src_a     (src_a),
        .src_b     (src_b),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .result    (result),
        .tag_out   (tag_out)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model written straight from the op table.
    function automatic logic [31:0] model_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned n;
        n = b % 32;
        case (op)
            4'd0:  return a & b;
            4'd1:  return a ^ b;
            4'd2:  return a | b;
            4'd3:  return a + b;
            4'd4:  return a - b;
            4'd5:  return (a == b) ? 32'd1 : 32'd0;
            4'd6:  return (a != b) ? 32'd1 : 32'd0;
            4'd7:  return ($signed(a) <  $signed(b)) ? 32'd1 : 32'd0;
            4'd8:  return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  return a >> n;
            4'd10: return a << n;
            4'd11: return 32'($signed(a) >>> n);
            4'd12: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
        int n;
        n = int'(b % 32);
        if ((op == 4'd9 || op == 4'd10 || op == 4'd11) && n != 0) return n + 1;
        return 1;
    endfunction

    // Call just after a rising edge with the unit idle.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tg);
        int lat, low, el;
        bit seen;
        logic [31:0] er;
        er = model_res(op, a, b);
        el = model_lat(op, b);
        operation = op; src_a = a; src_b = b; tag_in = tg; in_valid = 1'b1;
        chk("ready_at_issue", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1; low = 0; seen = 0;
        while (!seen && lat <= 40) begin
            if (out_valid) seen = 1;
            else begin
                if (!in_ready) low++;
                @(posedge clk); #1;
                lat++;
            end
        end
        chk("done_seen", seen, 1);
        chk("latency", lat, el);
        chk("result", result, er);
        chk("tag", tag_out, tg);
        chk("ready_at_done", in_ready, 1);
        chk("ready_low_cycles", low, el - 1);
    endtask

    initial begin
        logic [3:0]  b2b_op [3];
        logic [31:0] b2b_a  [3];
        logic [31:0] b2b_b  [3];
        int lat, pulses;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b1;
        operation = 4'd3; src_a = 32'd1; src_b = 32'd2; tag_in = 5'd7;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        reset = 1'b0; in_valid = 1'b0;
        chk("rst_ready", in_ready, 1);
        chk("rst_tag", tag_out, 0);
        @(posedge clk); #1;
        chk("post_rst_no_valid", out_valid, 0);

        // Back-to-back single-cycle ops.
        b2b_op[0] = 4'd4;  b2b_a[0] = 32'd5;          b2b_b[0] = 32'd7;
        b2b_op[1] = 4'd8;  b2b_a[1] = 32'hFFFF_FFFF;  b2b_b[1] = 32'd0;
        b2b_op[2] = 4'd12; b2b_a[2] = 32'd0;          b2b_b[2] = 32'h1234_5000;
        for (int i = 0; i < 3; i++) begin
            operation = b2b_op[i]; src_a = b2b_a[i]; src_b = b2b_b[i];
            tag_in = 5'(i + 1); in_valid = 1'b1;
            @(posedge clk); #1;
            chk("b2b_valid", out_valid, 1);
            chk("b2b_result", result, model_res(b2b_op[i], b2b_a[i], b2b_b[i]));
            chk("b2b_tag", tag_out, 5'(i + 1));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("b2b_pulse_end", out_valid, 0);

        run_op(4'd11, 32'h8000_0000, 32'd4, 5'd21);
        run_op(4'd10, 32'h0000_00F3, 32'd0, 5'd11);
        run_op(4'd14, 32'hDEAD_BEEF, 32'h1234_5678, 5'd2);
        run_op(4'd5, 32'd7, 32'd7, 5'd3);
        run_op(4'd6, 32'd7, 32'd7, 5'd4);
        run_op(4'd7, 32'h8000_0000, 32'd1, 5'd5);

        // SRL by 31 with an ADD waiting on the inputs throughout.
        operation = 4'd9; src_a = 32'hFFFF_FFFF; src_b = 32'd31; tag_in = 5'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        operation = 4'd3; src_a = 32'd3; src_b = 32'd4; tag_in = 5'd4;
        lat = 1;
        while (!out_valid && lat <= 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("srl31_latency", lat, 32);
        chk("srl31_result", result, 32'd1);
        chk("srl31_tag", tag_out, 3);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("held_add_valid", out_valid, 1);
        chk("held_add_result", result, 32'd7);
        chk("held_add_tag", tag_out, 4);
        @(posedge clk); #1;

        // Flush on the 3rd shift cycle of an SLL by 10.
        run_op(4'd3, 32'd1, 32'd2, 5'd9);
        operation = 4'd10; src_a = 32'd1; src_b = 32'd10; tag_in = 5'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_no_valid", out_valid, 0);
        chk("flush_result_kept", result, 32'd3);
        chk("flush_tag_kept", tag_out, 9);
        chk("flush_ready", in_ready, 1);
        run_op(4'd2, 32'hF0, 32'h0F, 5'd6);
        // Flush while idle drops the same-cycle op.
        operation = 4'd3; src_a = 32'd100; src_b = 32'd1; tag_in = 5'd1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            if (out_valid) pulses++;
            @(posedge clk); #1;
        end
        chk("flush_stray_pulses", pulses, 0);
        chk("flush_idle_result", result, 32'hFF);

        // Randomized ops against the model.
        for (int i = 0; i < 60; i++) begin
            logic [3:0]  rop;
            logic [31:0] ra, rb;
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 3) == 0) rb = ra;
            run_op(rop, ra, rb, 5'($urandom_range(0, 31)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
